// File: rtl/sr_cmd_driver.sv
// -----------------------------------------------------------------------------
// sr_cmd_driver
//   Command front end for an SR flip-flop. Two raw, asynchronous request inputs
//   are synchronised, debounced and edge-detected. Each accepted press becomes a
//   fixed-width pulse on s or r. s and r are never high together, so S=R=1 can
//   never reach the flip-flop.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronised samples needed to accept a level change (1..255)
//   PULSE_CYCLES     width of each s / r pulse in clk cycles (1..255)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   set_in    in   raw set request (async, active-high)
//   clr_in    in   raw clear request (async, active-high)
//   s         out  registered set drive
//   r         out  registered reset drive
//   busy      out  high during a pulse and its trailing gap cycle
//   conflict  out  one-cycle pulse when set and clear compete in one arbitration
//
// Configuration
//   SR_CMD_CONFLICT_DROP_EN  when defined, a set/clear conflict drops both
//                            requests instead of letting clear win.
// -----------------------------------------------------------------------------
module sr_cmd_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam int             CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]     PULSE_LAST = 8'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_S = 2'd1,
        DRIVE_R = 2'd2,
        GAP     = 2'd3
    } state_e;

    // Index 0 carries the set path, index 1 the clear path.
    logic [1:0]    raw_in;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    deb_q;
    logic [1:0]    deb_dly_q;
    logic [1:0]    req_q;
    logic [1:0]    pend_q;
    logic [1:0]    want_d;
    logic [CW-1:0] db_cnt_q [2];

    state_e        state_q;
    logic [7:0]    pulse_cnt_q;
    logic          s_q;
    logic          r_q;
    logic          busy_q;
    logic          conflict_q;

    assign raw_in   = {clr_in, set_in};
    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

    // Synchronise, debounce and edge-detect both request inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            deb_q       <= 2'b00;
            deb_dly_q   <= 2'b00;
            req_q       <= 2'b00;
            db_cnt_q[0] <= {CW{1'b0}};
            db_cnt_q[1] <= {CW{1'b0}};
        end else begin
            sync1_q   <= raw_in;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            // Only a debounced 0->1 transition is a press.
            req_q     <= deb_q & ~deb_dly_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    // The sample that would make the count reach DEBOUNCE_CYCLES
                    // flips the debounced level directly.
                    if (db_cnt_q[i] == DB_LAST) begin
                        deb_q[i]    <= ~deb_q[i];
                        db_cnt_q[i] <= {CW{1'b0}};
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + CW'(1);
                    end
                end else begin
                    db_cnt_q[i] <= {CW{1'b0}};
                end
            end
        end
    end

    // A request is visible to arbitration in the cycle it is registered,
    // so an idle FSM reacts without waiting for the pending flag.
    always_comb begin
        want_d = pend_q | req_q;
    end

    // Command FSM with registered s / r / busy / conflict decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pulse_cnt_q <= 8'd0;
            pend_q      <= 2'b00;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            busy_q      <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            conflict_q <= 1'b0;
            case (state_q)
                // GAP arbitrates exactly like IDLE on its exit edge, so a queued
                // request starts right after the single gap cycle.
                IDLE, GAP: begin
                    pend_q      <= 2'b00;
                    pulse_cnt_q <= 8'd0;
                    if (want_d[0] && want_d[1]) begin
                        conflict_q <= 1'b1;
`ifdef SR_CMD_CONFLICT_DROP_EN
                        state_q    <= IDLE;
                        s_q        <= 1'b0;
                        r_q        <= 1'b0;
                        busy_q     <= 1'b0;
`else
                        state_q    <= DRIVE_R;
                        s_q        <= 1'b0;
                        r_q        <= 1'b1;
                        busy_q     <= 1'b1;
`endif
                    end else if (want_d[1]) begin
                        state_q <= DRIVE_R;
                        s_q     <= 1'b0;
                        r_q     <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (want_d[0]) begin
                        state_q <= DRIVE_S;
                        s_q     <= 1'b1;
                        r_q     <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                DRIVE_S, DRIVE_R: begin
                    // Queue one request per input; repeats are absorbed.
                    pend_q <= want_d;
                    if (pulse_cnt_q == PULSE_LAST) begin
                        state_q     <= GAP;
                        pulse_cnt_q <= 8'd0;
                        s_q         <= 1'b0;
                        r_q         <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    pulse_cnt_q <= 8'd0;
                    pend_q      <= 2'b00;
                    s_q         <= 1'b0;
                    r_q         <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_driver
//   Three instances (D=4 with P=1, P=3, P=4) driven by directed stimulus.
//   Stimulus pushes expected pulse records {dut, signal, start edge, width} and
//   scalar checks into queues; a negedge monitor measures every completed pulse
//   on s / r / busy / conflict and pops the matching expectation.
//   Edge numbers are values of cyc, which advances on every rising edge.
// -----------------------------------------------------------------------------
module tb_sr_cmd_driver;

    logic clk = 1'b0;
    int   cyc = 0;

    logic rst_a_n, rst_b_n, rst_c_n;
    logic set_a, clr_a, set_b, clr_b, set_c, clr_c;
    logic s_a, r_a, busy_a, conflict_a;
    logic s_b, r_b, busy_b, conflict_b;
    logic s_c, r_c, busy_c, conflict_c;

    typedef struct {
        int dut;
        int typ;
        int start;
        int width;
    } ev_t;

    typedef struct {
        string name;
        int    got;
        int    want;
    } chk_t;

    ev_t  exp_q [$];
    chk_t chk_q [$];

    int   checks = 0;
    int   errors = 0;
    logic done   = 1'b0;
    logic fin    = 1'b0;

    logic prev_v [3][4] = '{default: 1'b0};
    int   st_v   [3][4] = '{default: 0};
    int   hi_cnt [3][4] = '{default: 0};

    sr_cmd_driver #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_a_n), .set_in(set_a), .clr_in(clr_a),
        .s(s_a), .r(r_a), .busy(busy_a), .conflict(conflict_a)
    );

    sr_cmd_driver #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_b_n), .set_in(set_b), .clr_in(clr_b),
        .s(s_b), .r(r_b), .busy(busy_b), .conflict(conflict_b)
    );

    sr_cmd_driver #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(4)) u_c (
        .clk(clk), .rst_n(rst_c_n), .set_in(set_c), .clr_in(clr_c),
        .s(s_c), .r(r_c), .busy(busy_c), .conflict(conflict_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string tname(input int t);
        case (t)
            0:       return "s";
            1:       return "r";
            2:       return "busy";
            default: return "conflict";
        endcase
    endfunction

    task automatic push_ev(input int d, input int t, input int st, input int w);
        ev_t e;
        e.dut = d; e.typ = t; e.start = st; e.width = w;
        exp_q.push_back(e);
    endtask

    task automatic push_chk(input string n, input int got, input int want);
        chk_t c;
        c.name = n; c.got = got; c.want = want;
        chk_q.push_back(c);
    endtask

    task automatic report(input int d, input int t, input int st, input int w);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].dut == d && exp_q[i].typ == t) idx = i;
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_pulse dut=%0d sig=%s got start=%0d width=%0d, required none",
                     d, tname(t), st, w);
        end else begin
            if (exp_q[idx].start != st || exp_q[idx].width != w) begin
                errors++;
                $display("FAIL pulse_timing dut=%0d sig=%s got start=%0d width=%0d, required start=%0d width=%0d",
                         d, tname(t), st, w, exp_q[idx].start, exp_q[idx].width);
            end
            exp_q.delete(idx);
        end
    endtask

    task automatic observe(input int d, input logic rstn, input logic [3:0] v);
        // v = {conflict, busy, r, s}
        if (rstn !== 1'b1) begin
            checks++;
            if (v !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs dut=%0d got {c,b,r,s}=%b required 0000", d, v);
            end
        end
        checks++;
        if (v[0] === 1'b1 && v[1] === 1'b1) begin
            errors++;
            $display("FAIL s_r_exclusive dut=%0d got s=1 r=1 at edge %0d, required not both", d, cyc);
        end
        for (int t = 0; t < 4; t++) begin
            if (v[t] === 1'b1) hi_cnt[d][t]++;
            if (v[t] === 1'b1 && !prev_v[d][t]) begin
                st_v[d][t] = cyc;
            end else if (v[t] !== 1'b1 && prev_v[d][t]) begin
                report(d, t, st_v[d][t], cyc - st_v[d][t]);
            end
            prev_v[d][t] = (v[t] === 1'b1);
        end
    endtask

    // Monitor: measure pulses, consume expectations, settle leftovers at the end.
    always @(negedge clk) begin
        chk_t c;
        observe(0, rst_a_n, {conflict_a, busy_a, r_a, s_a});
        observe(1, rst_b_n, {conflict_b, busy_b, r_b, s_b});
        observe(2, rst_c_n, {conflict_c, busy_c, r_c, s_c});
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            checks++;
            if (c.got != c.want) begin
                errors++;
                $display("FAIL %s got %0d required %0d", c.name, c.got, c.want);
            end
        end
        if (done && !fin) begin
            checks++;
            if (exp_q.size() != 0) errors++;
            foreach (exp_q[i]) begin
                $display("FAIL missing_pulse dut=%0d sig=%s required start=%0d width=%0d, got none",
                         exp_q[i].dut, tname(exp_q[i].typ), exp_q[i].start, exp_q[i].width);
            end
            fin = 1'b1;
        end
    end

    initial begin
        int e;
        int s0, r0, b0;

        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        set_a = 1'b0; clr_a = 1'b0; set_b = 1'b0; clr_b = 1'b0; set_c = 1'b0; clr_c = 1'b0;

        // Reset held with inputs toggling: every output must stay 0.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_a = i[0]; clr_a = i[1];
            set_b = i[1]; clr_b = i[0];
            set_c = i[0]; clr_c = ~i[0];
        end
        @(negedge clk);
        set_a = 1'b0; clr_a = 1'b0; set_b = 1'b0; clr_b = 1'b0; set_c = 1'b0; clr_c = 1'b0;
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single set press, P=1: s at edge 8 for 1 cycle, busy edges 8-9.
        @(negedge clk);
        set_a = 1'b1; e = cyc + 1;
        push_ev(0, 0, e + 7, 1);
        push_ev(0, 2, e + 7, 2);
        repeat (14) @(negedge clk);
        set_a = 1'b0;
        repeat (10) @(negedge clk);

        // Glitch of 3 sampled cycles on clr: nothing happens.
        r0 = hi_cnt[0][1]; b0 = hi_cnt[0][2];
        @(negedge clk);
        clr_a = 1'b1;
        repeat (3) @(negedge clk);
        clr_a = 1'b0;
        repeat (12) @(negedge clk);
        push_chk("glitch_r_cycles", hi_cnt[0][1] - r0, 0);
        push_chk("glitch_busy_cycles", hi_cnt[0][2] - b0, 0);

        // Simultaneous press: conflict at edge 8, clear wins (or both dropped).
        s0 = hi_cnt[0][0]; r0 = hi_cnt[0][1]; b0 = hi_cnt[0][2];
        @(negedge clk);
        set_a = 1'b1; clr_a = 1'b1; e = cyc + 1;
        push_ev(0, 3, e + 7, 1);
`ifndef SR_CMD_CONFLICT_DROP_EN
        push_ev(0, 1, e + 7, 1);
        push_ev(0, 2, e + 7, 2);
`endif
        repeat (14) @(negedge clk);
        push_chk("conflict_s_cycles", hi_cnt[0][0] - s0, 0);
`ifdef SR_CMD_CONFLICT_DROP_EN
        push_chk("conflict_drop_r_cycles", hi_cnt[0][1] - r0, 0);
        push_chk("conflict_drop_busy_cycles", hi_cnt[0][2] - b0, 0);
`endif
        set_a = 1'b0; clr_a = 1'b0;
        repeat (10) @(negedge clk);

        // Back-to-back, P=3: clear request registered during DRIVE_S is queued.
        @(negedge clk);
        set_b = 1'b1; e = cyc + 1;
        repeat (2) @(negedge clk);
        clr_b = 1'b1;                  // press edge e+2, request at e+8
        push_ev(1, 0, e + 7, 3);
        push_ev(1, 1, e + 11, 3);
        push_ev(1, 2, e + 7, 8);
        repeat (20) @(negedge clk);
        set_b = 1'b0; clr_b = 1'b0;
        repeat (10) @(negedge clk);

        // Reset during the second s cycle, P=4, then a fresh press after release.
        @(negedge clk);
        set_c = 1'b1; e = cyc + 1;
        push_ev(2, 0, e + 7, 2);
        push_ev(2, 2, e + 7, 2);
        repeat (9) @(posedge clk);     // edge e+8: second cycle of s
        #7;
        rst_c_n = 1'b0;
        #1;
        push_chk("reset_truncates_s", int'(s_c), 0);
        push_chk("reset_clears_busy", int'(busy_c), 0);
        repeat (4) @(negedge clk);
        rst_c_n = 1'b1; e = cyc + 1;
        push_ev(2, 0, e + 7, 4);
        push_ev(2, 2, e + 7, 5);
        repeat (16) @(negedge clk);
        set_c = 1'b0;
        repeat (10) @(negedge clk);

        done = 1'b1;
        repeat (3) @(negedge clk);
        if (!fin) $display("FAIL monitor_handshake got fin=0 required fin=1");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_cmd_driver.md
# sr_cmd_driver

Upstream command stage for `sr_flip_flop`. It synchronises and debounces two raw request inputs (set, clear) and converts each debounced press into a clean, fixed-width `s` or `r` pulse. `s` and `r` are never high together, so the forbidden S=R=1 condition can never reach the flip-flop. Requests arriving while a pulse is in progress are queued one-deep per input, and simultaneous requests are arbitrated deterministically.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required to accept a level change; legal range 1..255.
- `PULSE_CYCLES`, 1: width of each `s`/`r` pulse in clk cycles; legal range 1..255.

Ports:
- `clk`  input  1  single clock; all logic on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `set_in`  input  1  raw set request, asynchronous to `clk`, active-high.
- `clr_in`  input  1  raw clear request, asynchronous to `clk`, active-high.
- `s`  output  1  registered set drive to `sr_flip_flop.s`.
- `r`  output  1  registered reset drive to `sr_flip_flop.r`.
- `busy`  output  1  high while a pulse or the following gap is in progress.
- `conflict`  output  1  one-cycle pulse when both requests compete in the same arbitration cycle.

## Operation
- **Reset.** `rst_n` low immediately clears `s`, `r`, `busy` and `conflict` to 0. It also clears the synchronisers, debounced levels, counters, pending flags and the FSM (state IDLE).
- **Synchronisation.** Each input passes through a 2-flop synchroniser.
- **Debounce.** Each input has its own counter, `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
  - The counter increments each cycle the synchronised level differs from the debounced level.
  - It clears whenever the two levels match.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears.
- **Edge detect.** A debounced 0→1 transition produces a registered one-cycle request (`set_req` / `clr_req`). A 1→0 transition produces nothing.
- **Pending flags.** A request sets that input's pending flag. The flag clears when the FSM starts servicing it. A second request of the same type while its flag is already set is absorbed: no counting, no error.
- **FSM states:** IDLE, DRIVE_S, DRIVE_R, GAP.
  - IDLE, only set pending → DRIVE_S.
  - IDLE, only clear pending → DRIVE_R.
  - IDLE, both pending → `conflict`=1 for one cycle, then DRIVE_R (clear wins); both pending flags clear.
  - DRIVE_S / DRIVE_R: hold `s` (resp. `r`) high for exactly `PULSE_CYCLES` cycles → GAP.
  - GAP: one cycle with `s`=`r`=0 → IDLE.
- **Outputs.**
  - `busy` = 1 in DRIVE_S, DRIVE_R and GAP.
  - `s` and `r` are registered decodes of state and are mutually exclusive in every cycle.
  - A request that is in the same cycle as the edge that enters IDLE is serviced on the next edge; requests are never lost.
- **Reset mid-pulse.** The pulse is truncated immediately. After release, an input still held high is treated as a new press once debounce completes, because debounced levels restart at 0.

## Timing
- Count edges from edge 1, the first rising edge that samples the raw input high (the input is held stable from then on):
  - edge 2: synchroniser output high
  - edge 2+D: debounced level high (D = `DEBOUNCE_CYCLES`)
  - edge 3+D: request registered
  - edge 4+D: FSM leaves IDLE; `s`/`r` high from this edge on
- Press-to-pulse latency is D+4 edges when the FSM is idle.
- The pulse occupies `PULSE_CYCLES` cycles, followed by 1 GAP cycle. Minimum spacing between consecutive pulses is `PULSE_CYCLES`+1 cycles.
- A glitch on the raw input shorter than D synchronised cycles produces no pulse.
- `conflict` is high in the same cycle as the first DRIVE_R cycle it causes.

## Configuration
- Macro `SR_CMD_CONFLICT_DROP_EN`.
- **Undefined (default):** on a conflict, clear wins as described above and `r` is driven.
- **Defined:** on a conflict, both pending flags clear, `conflict` pulses, the FSM stays in IDLE and neither `s` nor `r` is driven; `busy` stays 0.

## Test plan
- **Reset values:** `rst_n`=0 with the inputs toggling → `s`=`r`=`busy`=`conflict`=0 throughout. Release, with D=4 and P=1.
- **Single set:** `set_in` held high from edge 1 → `s` high for exactly 1 cycle starting at edge 8; `busy` high for edges 8–9; `r` stays 0.
- **Glitch rejection:** `clr_in` high for 3 sampled cycles, then low (D=4) → no `r` pulse, `busy` stays 0.
- **Simultaneous press:** `set_in` and `clr_in` rise on the same edge → `conflict` and `r` high at edge 8; `s` never high. With `SR_CMD_CONFLICT_DROP_EN` defined → `conflict` at edge 8, `r`=`s`=`busy`=0.
- **Back-to-back:** with P=3, a set press followed by a clear request registered while DRIVE_S is active → `s` high for 3 cycles, 1 gap cycle, then `r` high for 3 cycles; `s`&`r` is never 1.
- **Reset mid-pulse:** with P=4, assert `rst_n`=0 during the second cycle of `s` → `s` falls immediately with no further pulse. After release with `set_in` still high → a new `s` pulse D+4 edges later.
